// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between spi_reg_ctrl, the byte-level SPI slave and the register bank.
// The slave modport is the controller's view; master is the surrounding logic's view.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              start_i;
  logic              end_i;
  logic [7:0]        tx_data_o;
  logic              tx_wr_en_o;
  logic              tx_ack_i;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [7:0]        reg_wdata_o;
  logic              reg_we_o;
  logic              reg_re_o;
  logic [7:0]        reg_rdata_i;
  logic              busy_o;
  logic              err_o;

  modport slave (
    input  rx_data_i, rx_valid_i, start_i, end_i, tx_ack_i, reg_rdata_i,
    output tx_data_o, tx_wr_en_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
           busy_o, err_o
  );

  modport master (
    output rx_data_i, rx_valid_i, start_i, end_i, tx_ack_i, reg_rdata_i,
    input  tx_data_o, tx_wr_en_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
           busy_o, err_o
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Frame-level SPI register protocol: a command byte (bit7 = read) selects the start
// address, then data bytes stream into registers or registers are prefetched for transmit.
module spi_reg_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int AUTO_INC = 1
) (
  input logic           clk,
  input logic           rst_n,
  spi_reg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_REQ,
    RD_CAP,
    RD_LOAD,
    RD_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  assign addr_inc = addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tx_data_q <= 8'hFF;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      err_q     <= err_d;
    end
  end

  // Write strobes are registered so a byte arriving with end_i or start_i still lands.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    we_d      = bus.rx_valid_i && (state_q == WR);
    wdata_d   = we_d ? bus.rx_data_i : wdata_q;
    err_d     = bus.rx_valid_i &&
                ((state_q == RD_REQ) || (state_q == RD_CAP) || (state_q == RD_LOAD));

    if (we_q && (AUTO_INC != 0)) begin
      addr_d = addr_inc;
    end

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      CMD: begin
        if (bus.rx_valid_i) begin
          addr_d  = bus.rx_data_i[ADDR_W-1:0];
          state_d = bus.rx_data_i[7] ? RD_REQ : WR;
        end
      end
      WR: begin
        state_d = WR;
      end
      RD_REQ: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        tx_data_d = bus.reg_rdata_i;
        state_d   = RD_LOAD;
      end
      RD_LOAD: begin
        if (bus.tx_ack_i) begin
          state_d = RD_WAIT;
          if (AUTO_INC != 0) begin
            addr_d = addr_inc;
          end
        end
      end
      RD_WAIT: begin
        if (bus.rx_valid_i) begin
          state_d = RD_REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Chip-select edges override everything; a new frame start beats a frame end.
    if (bus.start_i) begin
      state_d   = CMD;
      tx_data_d = 8'hFF;
    end else if (bus.end_i) begin
      state_d   = IDLE;
      tx_data_d = 8'hFF;
    end
  end

  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_wr_en_o  = (state_q == RD_LOAD);
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_we_o    = we_q;
  assign bus.reg_re_o    = (state_q == RD_REQ);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.err_o       = err_q;

endmodule
